led_flash_ctrl: RTL



---
 rtl/led_flash_pkg.sv | 75 +++++++
 rtl/led_flash_ctrl_edge_sync.sv | 27 ++
 rtl/led_flash_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/led_flash_pkg.sv
// LED flash controller shared types and helpers.
// Mode/state encodings, entry patterns, one-hot check.
package led_flash_pkg;

  localparam int unsigned LED_MAX = 32;

  typedef enum logic [1:0] {
    MODE_SHL    = 2'd0,
    MODE_SHR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_SHL    = 3'd0,
    S_SHR    = 3'd1,
    S_BNC_UP = 3'd2,
    S_BNC_DN = 3'd3,
    S_BLINK  = 3'd4
  } state_e;

  function automatic logic [LED_MAX-1:0] entry_pattern(
    input mode_e       m,
    input int unsigned n
  );
    logic [LED_MAX-1:0] r;
    logic [LED_MAX-1:0] ones;
    r    = '0;
    ones = '1;
    unique case (m)
      MODE_SHL:    r[0] = 1'b1;
      MODE_SHR:    r[n-1] = 1'b1;
      MODE_BOUNCE: r[0] = 1'b1;
      MODE_BLINK:  r = ones >> (LED_MAX - n);
      default:     r[0] = 1'b1;
    endcase
    return r;
  endfunction

  function automatic state_e entry_state(input mode_e m);
    state_e s;
    unique case (m)
      MODE_SHL:    s = S_SHL;
      MODE_SHR:    s = S_SHR;
      MODE_BOUNCE: s = S_BNC_UP;
      MODE_BLINK:  s = S_BLINK;
      default:     s = S_SHL;
    endcase
    return s;
  endfunction

  function automatic logic in_family(
    input state_e s,
    input mode_e  m
  );
    logic r;
    unique case (m)
      MODE_SHL:    r = (s == S_SHL);
      MODE_SHR:    r = (s == S_SHR);
      MODE_BOUNCE: r = (s == S_BNC_UP) ||
                       (s == S_BNC_DN);
      MODE_BLINK:  r = (s == S_BLINK);
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_onehot(
    input logic [LED_MAX-1:0] v
  );
    return (v != '0) &&
           ((v & (v - LED_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/led_flash_ctrl_edge_sync.sv
// Synchroniser plus rising-edge detector.
// Ports: clk, rst_n, d (async in), pulse (1-clk strobe).
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/led_flash_ctrl.sv
// LED bank flash-pattern controller stepped by step_clk.
// Ports: clk, rst_n, step_clk, en, mode -> led, step_pulse, dir.
module led_flash_ctrl
  import led_flash_pkg::*;
#(
  parameter int LED_N       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_clk,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_N-1:0] led,
  output logic             step_pulse,
  output logic             dir
);

  state_e             state_q, state_d;
  logic [LED_N-1:0]   led_q, led_d;
  logic [LED_MAX-1:0] entry;
  mode_e              mode_m;
  logic               reload;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (step_clk),
    .pulse (step_pulse)
  );

  assign mode_m = mode_e'(mode);
  assign entry  = entry_pattern(mode_m, LED_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SHL;
      led_q   <= LED_N'(1);
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  // Reload on mode change, or on a corrupted
  // (non one-hot) moving pattern.
  always_comb begin
    reload = !in_family(state_q, mode_m) ||
             ((state_q != S_BLINK) &&
              !is_onehot(LED_MAX'(led_q)));
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    if (step_pulse && en) begin
      if (reload) begin
        state_d = entry_state(mode_m);
        led_d   = entry[LED_N-1:0];
      end else begin
        case (state_q)
          S_SHL:
            led_d = {led_q[LED_N-2:0],
                     led_q[LED_N-1]};
          S_SHR:
            led_d = {led_q[0],
                     led_q[LED_N-1:1]};
          S_BNC_UP:
            if (led_q[LED_N-1]) begin
              led_d   = {1'b0, led_q[LED_N-1:1]};
              state_d = S_BNC_DN;
            end else begin
              led_d = {led_q[LED_N-2:0], 1'b0};
            end
          S_BNC_DN:
            if (led_q[0]) begin
              led_d   = {led_q[LED_N-2:0], 1'b0};
              state_d = S_BNC_UP;
            end else begin
              led_d = {1'b0, led_q[LED_N-1:1]};
            end
          S_BLINK:
            led_d = ~led_q;
          default: begin
            state_d = S_SHL;
            led_d   = LED_N'(1);
          end
        endcase
      end
    end
  end

  always_comb begin
    dir = (state_q == S_SHR) ||
          (state_q == S_BNC_DN);
  end

  assign led = led_q;

endmodule
